// File: rtl/wb_stage.sv
// Write-back pipeline stage: one register between MEM and WB.
// Also generates the register-file write enable, WB->EX forwarding selects and a retire counter.
module wb_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_rs1,
  input  logic [ADDR_W-1:0] ex_rs2,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              fwd1,
  output logic              fwd2,
  output logic [31:0]       retire_cnt
);

  // The highest register address is hard-wired to zero and is never written.
  localparam logic [ADDR_W-1:0] ZERO_REG = '1;

  logic              valid_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       retire_q;

  logic [DATA_W-1:0] mem_wb_data;
  logic              retire;

  assign mem_wb_data = mem_mem_to_reg ? mem_load_data : mem_alu_result;

  // An instruction retires on the edge it leaves WB; a flush discards it instead.
  assign retire = valid_q && !stall && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else if (!stall) begin
      valid_q     <= mem_valid;
      reg_write_q <= mem_reg_write;
      rd_q        <= mem_rd;
      data_q      <= mem_wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (retire) begin
      retire_q <= retire_q + 32'd1;
    end
  end

  // Built from registered state only, so the write enable has no path from MEM, stall or flush.
  assign wb_en      = valid_q && reg_write_q && (rd_q != ZERO_REG);
  assign wb_rd      = rd_q;
  assign wb_data    = data_q;
  assign wb_valid   = valid_q;
  assign fwd1       = wb_en && (ex_rs1 == rd_q);
  assign fwd2       = wb_en && (ex_rs2 == rd_q);
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load write-back, zero register, bubbles,
// stall/flush priority, asynchronous reset and retire counter wrap.
module tb_wb_stage;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              mem_valid;
  logic              mem_reg_write;
  logic              mem_mem_to_reg;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] ex_rs1;
  logic [ADDR_W-1:0] ex_rs2;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              fwd1;
  logic              fwd2;
  logic [31:0]       retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_rd         (mem_rd),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .stall          (stall),
    .flush          (flush),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .wb_en          (wb_en),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_valid       (wb_valid),
    .fwd1           (fwd1),
    .fwd2           (fwd2),
    .retire_cnt     (retire_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] ld);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_mem_to_reg = m2r;
    mem_rd         = rd;
    mem_alu_result = alu;
    mem_load_data  = ld;
  endtask

  initial begin
    reset  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    ex_rs1 = '0;
    ex_rs2 = '0;
    // A live instruction is presented during reset; nothing may be written.
    drive(1'b1, 1'b1, 1'b0, 5'd3, 64'h1234, 64'h0);
    step();
    step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_en", 64'(wb_en), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_fwd", 64'({fwd1, fwd2}), 64'd0);

    // ALU write-back, 1-cycle latency
    reset = 1'b1;
    step();
    chk("alu_wb_en", 64'(wb_en), 64'd1);
    chk("alu_wb_rd", 64'(wb_rd), 64'd3);
    chk("alu_wb_data", wb_data, 64'h1234);
    chk("alu_wb_valid", 64'(wb_valid), 64'd1);
    chk("alu_retire", 64'(retire_cnt), 64'd0);

    // Load write-back with forwarding
    drive(1'b1, 1'b1, 1'b1, 5'd7, 64'h5, 64'hDEAD_BEEF);
    ex_rs1 = 5'd7;
    ex_rs2 = 5'd8;
    step();
    chk("ld_wb_data", wb_data, 64'hDEAD_BEEF);
    chk("ld_fwd1", 64'(fwd1), 64'd1);
    chk("ld_fwd2", 64'(fwd2), 64'd0);
    chk("ld_retire", 64'(retire_cnt), 64'd1);
    ex_rs2 = 5'd7;
    #1;
    chk("ld_fwd2_comb", 64'(fwd2), 64'd1);

    // Zero register
    drive(1'b1, 1'b1, 1'b0, 5'd31, 64'hAA, 64'h0);
    ex_rs1 = 5'd31;
    ex_rs2 = 5'd31;
    step();
    chk("x31_wb_en", 64'(wb_en), 64'd0);
    chk("x31_fwd1", 64'(fwd1), 64'd0);
    chk("x31_fwd2", 64'(fwd2), 64'd0);
    chk("x31_wb_valid", 64'(wb_valid), 64'd1);
    chk("x31_wb_rd", 64'(wb_rd), 64'd31);
    chk("x31_wb_data", wb_data, 64'hAA);
    chk("x31_retire", 64'(retire_cnt), 64'd2);

    // Bubble
    drive(1'b0, 1'b1, 1'b0, 5'd4, 64'h55, 64'h0);
    step();
    chk("bub_wb_valid", 64'(wb_valid), 64'd0);
    chk("bub_wb_en", 64'(wb_en), 64'd0);
    chk("bub_retire", 64'(retire_cnt), 64'd3);

    drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h77, 64'h0);
    ex_rs1 = 5'd5;
    step();
    chk("i5_wb_en", 64'(wb_en), 64'd1);
    chk("i5_fwd1", 64'(fwd1), 64'd1);
    chk("i5_retire", 64'(retire_cnt), 64'd3);

    // Stall 3 cycles: everything holds, no retire
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd9, 64'h99, 64'h9999);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_wb_rd", 64'(wb_rd), 64'd5);
      chk("stl_wb_data", wb_data, 64'h77);
      chk("stl_wb_en", 64'(wb_en), 64'd1);
      chk("stl_retire", 64'(retire_cnt), 64'd3);
    end

    // Flush beats stall
    flush = 1'b1;
    step();
    chk("fl_wb_valid", 64'(wb_valid), 64'd0);
    chk("fl_wb_en", 64'(wb_en), 64'd0);
    chk("fl_wb_rd", 64'(wb_rd), 64'd0);
    chk("fl_wb_data", wb_data, 64'd0);
    chk("fl_retire", 64'(retire_cnt), 64'd3);

    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd10, 64'h100, 64'h0);
    step();
    chk("i10_wb_en", 64'(wb_en), 64'd1);
    chk("i10_retire", 64'(retire_cnt), 64'd3);
    // wb_en must ignore MEM inputs, stall and flush between edges
    drive(1'b0, 1'b0, 1'b1, 5'd31, 64'h0, 64'h0);
    flush = 1'b1;
    stall = 1'b1;
    #1;
    chk("i10_en_indep", 64'(wb_en), 64'd1);

    // Asynchronous reset mid-stall/mid-flush, between edges
    reset = 1'b0;
    #1;
    chk("arst_wb_en", 64'(wb_en), 64'd0);
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_retire", 64'(retire_cnt), 64'd0);
    step();
    chk("arst_hold_en", 64'(wb_en), 64'd0);
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd2, 64'h22, 64'h0);
    step();
    chk("post_rst_wb_rd", 64'(wb_rd), 64'd2);
    chk("post_rst_wb_data", wb_data, 64'h22);
    chk("post_rst_retire", 64'(retire_cnt), 64'd0);

    // Retire counter wrap, preloaded between edges
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    chk("wrap_preload", 64'(retire_cnt), 64'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
    step();
    chk("wrap_zero", 64'(retire_cnt), 64'd0);
    step();
    chk("wrap_bubble", 64'(retire_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 64, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; address 2**ADDR_W-1 (X31) is the zero register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_valid  input  1  MEM stage holds a real instruction.
REQ-006 mem_reg_write  input  1  instruction writes a register.
REQ-007 mem_mem_to_reg  input  1  1 = write back load data, 0 = write back ALU result.
REQ-008 mem_rd  input  ADDR_W  destination register.
REQ-009 mem_alu_result  input  DATA_W  ALU result from MEM stage.
REQ-010 mem_load_data  input  DATA_W  load data from data memory.
REQ-011 stall  input  1  hold the WB register contents.
REQ-012 flush  input  1  load a bubble into the WB register.
REQ-013 ex_rs1, ex_rs2  input  ADDR_W each  EX-stage source registers for forwarding compare.
REQ-014 wb_en  output  1  register-file write enable; drives en of the write-address decoder tree.
REQ-015 wb_rd  output  ADDR_W  write address; drives the sel inputs of the decoder tree.
REQ-016 wb_data  output  DATA_W  write data.
REQ-017 wb_valid  output  1  WB register holds a real instruction.
REQ-018 fwd1, fwd2  output  1 each  forward wb_data to EX source operand 1 / 2.
REQ-019 retire_cnt  output  32  count of retired valid instructions.

Function
REQ-020 One pipeline register (valid, reg_write, rd, data) shall capture the MEM stage on each rising edge; latency MEM-to-WB shall be exactly 1 cycle.
REQ-021 Captured data shall be mem_load_data when mem_mem_to_reg=1, else mem_alu_result; selection happens before the register.
REQ-022 Priority per edge: flush > stall > capture.
REQ-023 flush=1: wb_valid<=0, reg_write<=0; rd and data shall be cleared to 0.
REQ-024 stall=1 (flush=0): all WB register fields shall hold their values.
REQ-025 wb_en shall equal wb_valid AND reg_write AND (wb_rd != 2**ADDR_W-1), combinationally from registered state.
REQ-026 Writes to X31 shall never assert wb_en; wb_data and wb_rd shall still show captured values.
REQ-027 fwd1 shall be 1 iff wb_en=1 and ex_rs1==wb_rd; fwd2 likewise with ex_rs2; X31 never forwards (follows from REQ-025).
REQ-028 retire_cnt shall increment by 1 on each edge where wb_valid=1 and stall=0 and flush=0, i.e. when the held instruction leaves WB.
REQ-029 retire_cnt shall wrap from 0xFFFFFFFF to 0 with no flag.
REQ-030 A stalled instruction shall be counted once, on the edge it leaves, regardless of stall duration.
REQ-031 mem_valid=0 captured without flush shall behave as a bubble: wb_valid=0, wb_en=0, no retire.
REQ-032 wb_en shall not depend combinationally on any MEM-stage input, stall, or flush.

Reset
REQ-033 reset=0 shall immediately, without a clock, force wb_valid=0, wb_rd=0, wb_data=0, reg_write=0, retire_cnt=0; hence wb_en=0, fwd1=fwd2=0.
REQ-034 Reset asserted mid-stall or mid-flush shall override both; the first edge after reset=1 performs a normal capture.
REQ-035 No register write shall be signalled while reset=0.

Verification
REQ-036 Reset then one ALU instruction: mem_valid=1, reg_write=1, mem_to_reg=0, rd=3, alu=0x1234 -> next cycle wb_en=1, wb_rd=3, wb_data=0x1234, wb_valid=1.
REQ-037 Load write-back: mem_to_reg=1, load=0xDEADBEEF, alu=0x5, rd=7 -> wb_data=0xDEADBEEF; ex_rs1=7, ex_rs2=8 -> fwd1=1, fwd2=0.
REQ-038 Zero register: rd=31, reg_write=1, ex_rs1=31 -> wb_en=0, fwd1=0, wb_valid=1, retire_cnt increments on the next unstalled edge.
REQ-039 Stall 3 cycles then flush with stall still high: outputs hold for 3 cycles, retire_cnt unchanged; after flush edge wb_valid=0, wb_en=0, retire_cnt unchanged.
REQ-040 Async reset: drive reset=0 between edges while wb_en=1 -> wb_en=0, retire_cnt=0 before the next edge.
REQ-041 Wrap: preload retire_cnt to 0xFFFFFFFF via 2**32-1 retirements (or force) then retire one -> retire_cnt=0.
